data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_lane_align.sv | 49 ++++
 rtl/data_mem_responder.sv | 120 ++++++++++++
 tb/tb_data_mem_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and RV32 load/store width codes for the data memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Stores have no unsigned variants, so only b/h/w are legal for them.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores, extraction/extension for loads, and alignment check.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = 8'(rword >> {addr_lo, 3'b000});
        half_sel   = addr_lo[1] ? rword[31:16] : rword[15:0];
        byte_en    = 4'b0000;
        wdata_lane = '0;
        rdata_ext  = '0;
        misalign   = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = (funct3 == F3_B) ? {{24{byte_sel[7]}}, byte_sel}
                                              : {24'd0, byte_sel};
            end
            F3_H, F3_HU: begin
                misalign   = addr_lo[0];
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = (funct3 == F3_H) ? {{16{half_sel[15]}}, half_sel}
                                              : {16'd0, half_sel};
            end
            F3_W: begin
                misalign   = |addr_lo;
                byte_en    = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory with fixed response latency and request error checks.
// state | meaning
// IDLE  | ready for a request
// WAIT  | request captured, latency counter running
// RESP  | response held until resp_ready
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = 4;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          cap_we;
    logic [2:0]    cap_funct3;
    logic [31:0]   cap_addr, cap_wdata;
    logic [31:0]   mem [DEPTH];

    logic          accept, enter_resp, err;
    logic          cur_we;
    logic [2:0]    cur_funct3;
    logic [31:0]   cur_addr, cur_wdata;
    logic [AW-1:0] idx;
    logic [3:0]    byte_en;
    logic [31:0]   wdata_lane, rdata_ext;
    logic          misalign;

    assign accept     = req_valid && req_ready;
    assign enter_resp = (state != RESP) && (state_nxt == RESP);

    // With LATENCY 1 the access happens on the accept edge, before capture.
    assign cur_we     = (state == IDLE) ? req_we     : cap_we;
    assign cur_funct3 = (state == IDLE) ? req_funct3 : cap_funct3;
    assign cur_addr   = (state == IDLE) ? req_addr   : cap_addr;
    assign cur_wdata  = (state == IDLE) ? req_wdata  : cap_wdata;

    assign idx = cur_addr[AW+1:2];
    assign err = misalign || (|cur_addr[31:AW+2]) || !f3_legal(cur_we, cur_funct3);

    dmem_lane_align u_lane_align (
        .funct3     (cur_funct3),
        .addr_lo    (cur_addr[1:0]),
        .wdata      (cur_wdata),
        .rword      (mem[idx]),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext),
        .misalign   (misalign)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            cap_we     <= 1'b0;
            cap_funct3 <= '0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt        <= CW'(LATENCY - 1);
                cap_we     <= req_we;
                cap_funct3 <= req_funct3;
                cap_addr   <= req_addr;
                cap_wdata  <= req_wdata;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            if (enter_resp) begin
                resp_err   <= err;
                resp_rdata <= (err || cur_we) ? 32'd0 : rdata_ext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (enter_resp && cur_we && !err) begin
            for (int b = 0; b < 4; b++)
                if (byte_en[b]) mem[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = (LATENCY == 1) ? RESP : WAIT;
            WAIT: if (cnt <= CW'(1)) state_nxt = RESP;
            RESP: if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = rstn && (state == IDLE);
        resp_valid = (state == RESP);
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: directed scenarios plus random traffic against a byte-array model.
module tb_data_mem_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_ready = 1'b0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] mem_b [4*DEPTH];

    data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        foreach (mem_b[i]) mem_b[i] = 8'd0;
    endfunction

    // Little-endian byte memory; width is 1 << funct3[1:0].
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic er);
        int size;
        logic legal;
        logic [31:0] v;
        size  = 1 << f3[1:0];
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        er    = !legal || (addr >= 4*DEPTH) || ((addr % size) != 0);
        rd    = 32'd0;
        if (er) return;
        v = 32'd0;
        for (int k = 0; k < size; k++) begin
            if (we) mem_b[addr+k] = wd[8*k +: 8];
            else    v[8*k +: 8] = mem_b[addr+k];
        end
        if (!we) begin
            rd = v;
            if (!f3[2] && size == 1 && v[7])  rd = v - 32'd256;
            if (!f3[2] && size == 2 && v[15]) rd = v - 32'd65536;
        end
    endfunction

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input int stall,
                          output logic [31:0] rd, output logic er);
        logic [31:0] exp_rd, hold_rd;
        logic exp_er, hold_er;
        int n;
        model(we, f3, addr, wd, exp_rd, exp_er);
        @(negedge clk);
        check("ready_idle", req_ready, 1'b1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        @(negedge clk);
        // keep valid high with junk fields: nothing must be accepted or captured
        req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        check("ready_busy", req_ready, 1'b0);
        n = 1;
        while (!resp_valid && n < 4*LATENCY + 4) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) begin
            check("resp_timeout", resp_valid, 1'b1);
            req_valid = 1'b0; rd = 32'd0; er = 1'b0;
            return;
        end
        check("latency", n, LATENCY);
        check("rdata", resp_rdata, exp_rd);
        check("err", resp_err, exp_er);
        hold_rd = resp_rdata;
        hold_er = resp_err;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold_valid", resp_valid, 1'b1);
            check("hold_rdata", resp_rdata, hold_rd);
            check("hold_err", resp_err, hold_er);
            check("hold_ready", req_ready, 1'b0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        check("valid_drop", resp_valid, 1'b0);
        check("ready_back", req_ready, 1'b1);
        rd = hold_rd;
        er = hold_er;
    endtask

    initial begin
        logic [31:0] rd, w0;
        logic er;

        repeat (3) @(negedge clk);
        check("rst_ready", req_ready, 1'b0);
        check("rst_valid", resp_valid, 1'b0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_err", resp_err, 1'b0);
        rstn = 1'b1;
        model_clear();
        @(negedge clk);
        check("ready_after_rst", req_ready, 1'b1);

        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er);
        check("sw_10_err", er, 1'b0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er);
        check("lw_10", rd, 32'hDEADBEEF);
        do_req(1'b1, 3'b000, 32'h11, 32'h80, 0, rd, er);
        do_req(1'b0, 3'b000, 32'h11, 32'h0, 0, rd, er);
        check("lb_11", rd, 32'hFFFFFF80);
        do_req(1'b0, 3'b100, 32'h11, 32'h0, 0, rd, er);
        check("lbu_11", rd, 32'h00000080);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er);
        check("lw_10_merged", rd, 32'hDEAD80EF);
        do_req(1'b0, 3'b001, 32'h13, 32'h0, 0, rd, er);
        check("lh_13_err", er, 1'b1);
        check("lh_13_rdata", rd, 32'd0);
        do_req(1'b0, 3'b010, 32'h0, 32'h0, 0, w0, er);
        do_req(1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 0, rd, er);
        check("sw_400_err", er, 1'b1);
        do_req(1'b0, 3'b010, 32'h0, 32'h0, 0, rd, er);
        check("lw_0_unchanged", rd, w0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 5, rd, er);

        // reset one cycle after accepting a store: it must never commit or respond
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h20; req_wdata = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b0;
        rstn = 1'b0;
        @(negedge clk);
        check("abort_valid_in_rst", resp_valid, 1'b0);
        check("abort_ready_in_rst", req_ready, 1'b0);
        rstn = 1'b1;
        model_clear();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_resp", resp_valid, 1'b0);
        end
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 0, rd, er);
        check("lw_20_after_rst", rd, 32'd0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er);
        check("lw_10_after_rst", rd, 32'd0);

        for (int t = 0; t < 120; t++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1100)) : 32'($urandom_range(0, 63));
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom,
                   $urandom_range(0, 3), rd, er);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
